// File: rtl/axi_lite_timer_slave_if.sv
// AXI4-Lite bundle between the crossbar and the timer slot.
// The master modport drives requests; the slave modport answers them.
interface axi_lite_timer_slave_if #(
   parameter int ADDR_BW = 16,
   parameter int DATA_BW = 32
);
   logic [ADDR_BW-1:0]   s_axi_awaddr;
   logic                 s_axi_awvalid;
   logic                 s_axi_awready;
   logic [DATA_BW-1:0]   s_axi_wdata;
   logic [DATA_BW/8-1:0] s_axi_wstrb;
   logic                 s_axi_wvalid;
   logic                 s_axi_wready;
   logic [1:0]           s_axi_bresp;
   logic                 s_axi_bvalid;
   logic                 s_axi_bready;
   logic [ADDR_BW-1:0]   s_axi_araddr;
   logic                 s_axi_arvalid;
   logic                 s_axi_arready;
   logic [DATA_BW-1:0]   s_axi_rdata;
   logic [1:0]           s_axi_rresp;
   logic                 s_axi_rvalid;
   logic                 s_axi_rready;

   modport master (
      output s_axi_awaddr, s_axi_awvalid,
      output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
      output s_axi_bready,
      output s_axi_araddr, s_axi_arvalid,
      output s_axi_rready,
      input  s_axi_awready, s_axi_wready,
      input  s_axi_bresp, s_axi_bvalid,
      input  s_axi_arready,
      input  s_axi_rdata, s_axi_rresp, s_axi_rvalid
   );

   modport slave (
      input  s_axi_awaddr, s_axi_awvalid,
      input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
      input  s_axi_bready,
      input  s_axi_araddr, s_axi_arvalid,
      input  s_axi_rready,
      output s_axi_awready, s_axi_wready,
      output s_axi_bresp, s_axi_bvalid,
      output s_axi_arready,
      output s_axi_rdata, s_axi_rresp, s_axi_rvalid
   );
endinterface

// File: rtl/axi_lite_timer_slave.sv
// AXI4-Lite timer slot: prescaled 32-bit down-counter with
// optional auto-reload and a registered level interrupt.
module axi_lite_timer_slave #(
   parameter int          ADDR_BW    = 16,
   parameter int          DATA_BW    = 32,
   parameter logic [31:0] RESET_LOAD = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   axi_lite_timer_slave_if.slave  s_axi,
   output logic                   irq_o
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [9:0] IDX_CTRL   = 10'h000;
   localparam logic [9:0] IDX_STATUS = 10'h001;
   localparam logic [9:0] IDX_LOAD   = 10'h002;
   localparam logic [9:0] IDX_VALUE  = 10'h003;
   localparam logic [9:0] IDX_PRE    = 10'h004;

   logic        r_alive;
   logic        r_aw_held;
   logic [9:0]  r_aw_idx;
   logic        r_w_held;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   logic        r_bvalid;
   logic [1:0]  r_bresp;
   logic        r_rvalid;
   logic [31:0] r_rdata;
   logic [1:0]  r_rresp;

   logic [2:0]  r_ctrl;
   logic        r_expired;
   logic [31:0] r_load;
   logic [31:0] r_value;
   logic [15:0] r_prescale;
   logic [15:0] r_pcnt;
   logic        r_irq;

   logic        w_aw_hs;
   logic        w_w_hs;
   logic        w_ar_hs;
   logic        w_wr_go;
   logic        w_sel_ctrl;
   logic        w_sel_status;
   logic        w_sel_load;
   logic        w_sel_value;
   logic        w_sel_pre;
   logic        w_wr_ctrl;
   logic        w_en_rise;
   logic        w_tick;
   logic        w_expire;
   logic [31:0] w_mask;
   logic [9:0]  w_rd_idx;
   logic [31:0] w_rdata;
   logic [1:0]  w_rresp;
   logic        w_unused;

   // Readies stay low until the first clock after reset release.
   assign s_axi.s_axi_awready = r_alive & ~r_aw_held & ~r_bvalid;
   assign s_axi.s_axi_wready  = r_alive & ~r_w_held & ~r_bvalid;
   assign s_axi.s_axi_arready = r_alive & ~r_rvalid;
   assign s_axi.s_axi_bvalid  = r_bvalid;
   assign s_axi.s_axi_bresp   = r_bresp;
   assign s_axi.s_axi_rvalid  = r_rvalid;
   assign s_axi.s_axi_rdata   = r_rdata;
   assign s_axi.s_axi_rresp   = r_rresp;
   assign irq_o               = r_irq;

   assign w_aw_hs = s_axi.s_axi_awvalid & s_axi.s_axi_awready;
   assign w_w_hs  = s_axi.s_axi_wvalid & s_axi.s_axi_wready;
   assign w_ar_hs = s_axi.s_axi_arvalid & s_axi.s_axi_arready;
   assign w_wr_go = r_aw_held & r_w_held & ~r_bvalid;

   assign w_sel_ctrl   = w_wr_go & (r_aw_idx == IDX_CTRL);
   assign w_sel_status = w_wr_go & (r_aw_idx == IDX_STATUS);
   assign w_sel_load   = w_wr_go & (r_aw_idx == IDX_LOAD);
   assign w_sel_value  = w_wr_go & (r_aw_idx == IDX_VALUE);
   assign w_sel_pre    = w_wr_go & (r_aw_idx == IDX_PRE);

   assign w_mask = {{8{r_wstrb[3]}}, {8{r_wstrb[2]}},
                    {8{r_wstrb[1]}}, {8{r_wstrb[0]}}};

   assign w_wr_ctrl = w_sel_ctrl & r_wstrb[0];
   assign w_en_rise = w_wr_ctrl & r_wdata[0] & ~r_ctrl[0];
   assign w_tick    = r_ctrl[0] & (r_pcnt == r_prescale);
   assign w_expire  = w_tick & (r_value == 32'd0);

   assign w_rd_idx = s_axi.s_axi_araddr[11:2];
   assign w_unused = ^{s_axi.s_axi_araddr[ADDR_BW-1:12],
                       s_axi.s_axi_araddr[1:0],
                       s_axi.s_axi_awaddr[ADDR_BW-1:12],
                       s_axi.s_axi_awaddr[1:0]};

   always_comb begin
      w_rdata = 32'd0;
      w_rresp = RESP_OKAY;
      case (w_rd_idx)
         IDX_CTRL:   w_rdata = {29'd0, r_ctrl};
         IDX_STATUS: w_rdata = {31'd0, r_expired};
         IDX_LOAD:   w_rdata = r_load;
         IDX_VALUE:  w_rdata = r_value;
         IDX_PRE:    w_rdata = {16'd0, r_prescale};
         default:    w_rresp = RESP_SLVERR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alive   <= 1'b0;
         r_aw_held <= 1'b0;
         r_aw_idx  <= 10'd0;
         r_w_held  <= 1'b0;
         r_wdata   <= 32'd0;
         r_wstrb   <= 4'd0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
         r_rvalid  <= 1'b0;
         r_rdata   <= 32'd0;
         r_rresp   <= RESP_OKAY;
      end else begin
         r_alive <= 1'b1;
         if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_aw_idx  <= s_axi.s_axi_awaddr[11:2];
         end
         if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_wdata  <= s_axi.s_axi_wdata;
            r_wstrb  <= s_axi.s_axi_wstrb;
         end
         if (w_wr_go) begin
            r_bvalid <= 1'b1;
            r_bresp  <= (w_sel_ctrl | w_sel_status | w_sel_load |
                         w_sel_value | w_sel_pre) ? RESP_OKAY : RESP_SLVERR;
         end else if (r_bvalid & s_axi.s_axi_bready) begin
            r_bvalid  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
         end
         if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rdata;
            r_rresp  <= w_rresp;
         end else if (r_rvalid & s_axi.s_axi_rready) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ctrl     <= 3'd0;
         r_expired  <= 1'b0;
         r_load     <= RESET_LOAD;
         r_value    <= 32'd0;
         r_prescale <= 16'd0;
         r_pcnt     <= 16'd0;
         r_irq      <= 1'b0;
      end else begin
         r_irq <= r_expired & r_ctrl[2];
         if (w_sel_load)
            r_load <= (r_load & ~w_mask) | (r_wdata & w_mask);
         if (w_sel_pre)
            r_prescale <= (r_prescale & ~w_mask[15:0]) |
                          (r_wdata[15:0] & w_mask[15:0]);
         // A software CTRL write overrides the expiry self-disable.
         if (w_wr_ctrl)
            r_ctrl <= r_wdata[2:0];
         else if (w_expire & ~r_ctrl[1])
            r_ctrl[0] <= 1'b0;
         if (w_expire)
            r_expired <= 1'b1;
         else if (w_sel_status & r_wstrb[0] & r_wdata[0])
            r_expired <= 1'b0;
         if (w_en_rise) begin
            r_value <= r_load;
            r_pcnt  <= 16'd0;
         end else if (r_ctrl[0]) begin
            r_pcnt <= w_tick ? 16'd0 : r_pcnt + 16'd1;
            if (w_tick) begin
               if (r_value != 32'd0)
                  r_value <= r_value - 32'd1;
               else if (r_ctrl[1])
                  r_value <= r_load;
            end
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_timer_slave.sv
// Directed bench for the AXI4-Lite timer slot.
// Each task drives one scenario and checks its own results.
module tb_axi_lite_timer_slave;

   localparam logic [31:0] RL = 32'hA5A5_0001;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic irq;
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_fail = 0;

   axi_lite_timer_slave_if #(.ADDR_BW(16), .DATA_BW(32)) bus ();

   axi_lite_timer_slave #(
      .ADDR_BW(16), .DATA_BW(32), .RESET_LOAD(RL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .s_axi(bus.slave), .irq_o(irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_until(input int c);
      while (cyc < c) begin @(posedge clk); #1; end
   endtask

   task automatic axi_write(input logic [15:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp,
                            output int cc);
      int n; logic awd, wd, awh, wh;
      bus.s_axi_awaddr = a; bus.s_axi_wdata = d; bus.s_axi_wstrb = s;
      bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
      awd = 1'b0; wd = 1'b0; n = 0;
      while (!(awd && wd) && n < 40) begin
         awh = bus.s_axi_awvalid & bus.s_axi_awready;
         wh  = bus.s_axi_wvalid & bus.s_axi_wready;
         @(posedge clk); #1;
         if (awh) begin bus.s_axi_awvalid = 1'b0; awd = 1'b1; end
         if (wh)  begin bus.s_axi_wvalid = 1'b0; wd = 1'b1; end
         n++;
      end
      bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
      bus.s_axi_bready = 1'b1; n = 0;
      while (bus.s_axi_bvalid !== 1'b1 && n < 40) begin
         @(posedge clk); #1; n++;
      end
      cc = cyc;
      n_chk++;
      if (bus.s_axi_bvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL wr_timeout addr=%h bvalid=%b required 1", a, bus.s_axi_bvalid);
         resp = 2'b11;
      end else begin
         resp = bus.s_axi_bresp;
      end
      @(posedge clk); #1;
      bus.s_axi_bready = 1'b0;
   endtask

   task automatic axi_read(input logic [15:0] a, output logic [31:0] d,
                           output logic [1:0] resp, output int lat,
                           output int sc);
      int n; logic arh;
      bus.s_axi_araddr = a; bus.s_axi_arvalid = 1'b1;
      n = 0; arh = 1'b0; sc = -1;
      while (!arh && n < 40) begin
         arh = bus.s_axi_arvalid & bus.s_axi_arready;
         if (arh) sc = cyc;
         @(posedge clk); #1; n++;
      end
      bus.s_axi_arvalid = 1'b0;
      lat = 1;
      while (bus.s_axi_rvalid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      d = bus.s_axi_rdata; resp = bus.s_axi_rresp;
      n_chk++;
      if (bus.s_axi_rvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL rd_timeout addr=%h rvalid=%b required 1", a, bus.s_axi_rvalid);
      end
      bus.s_axi_rready = 1'b1;
      @(posedge clk); #1;
      bus.s_axi_rready = 1'b0;
   endtask

   task automatic test_reset;
      logic [15:0] addrs [5];
      logic [31:0] exps [5];
      logic [31:0] d; logic [1:0] r; int lat, sc;
      logic [39:0] outs;
      addrs = '{16'h1000, 16'h1004, 16'h1008, 16'h100C, 16'h1010};
      exps  = '{32'd0, 32'd0, RL, 32'd0, 32'd0};
      #12;
      outs = {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready,
              bus.s_axi_bvalid, bus.s_axi_rvalid, irq,
              bus.s_axi_bresp, bus.s_axi_rresp, bus.s_axi_rdata};
      n_chk++;
      if (outs !== 40'd0) begin
         n_fail++;
         $display("FAIL reset_outputs got=%h required 0", outs);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         axi_read(addrs[i], d, r, lat, sc);
         n_chk++;
         if (d !== exps[i] || r !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_read addr=%h got=%h/%b required %h/00", addrs[i], d, r, exps[i]);
         end
         n_chk++;
         if (lat !== 1) begin
            n_fail++;
            $display("FAIL read_latency addr=%h got=%0d required 1", addrs[i], lat);
         end
      end
   endtask

   task automatic test_oneshot;
      logic [31:0] d, e; logic [1:0] r; int lat, sc, c0;
      axi_write(16'h1008, 32'd5, 4'hF, r, c0);
      axi_write(16'h1010, 32'd0, 4'hF, r, c0);
      axi_write(16'h1000, 32'h1, 4'hF, r, c0);
      for (int i = 0; i < 3; i++) begin
         axi_read(16'h100C, d, r, lat, sc);
         e = (sc - c0 >= 5) ? 32'd0 : 32'(5 - (sc - c0));
         n_chk++;
         if (d !== e) begin
            n_fail++;
            $display("FAIL countdown sample=%0d got=%0d required %0d", sc - c0, d, e);
         end
      end
      wait_until(c0 + 10);
      axi_read(16'h1000, d, r, lat, sc);
      n_chk++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL oneshot_en_clr got=%h required 0", d); end
      axi_read(16'h100C, d, r, lat, sc);
      n_chk++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL oneshot_value got=%h required 0", d); end
      axi_read(16'h1004, d, r, lat, sc);
      n_chk++;
      if (d !== 32'd1) begin n_fail++; $display("FAIL oneshot_expired got=%h required 1", d); end
      n_chk++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked got=%b required 0", irq); end
      axi_write(16'h1004, 32'h1, 4'h1, r, c0);
      axi_read(16'h1004, d, r, lat, sc);
      n_chk++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL w1c_clear got=%h required 0", d); end
      axi_write(16'h1000, 32'h5, 4'hF, r, c0);
      wait_until(c0 + 6);
      n_chk++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early got=%b required 0", irq); end
      wait_until(c0 + 7);
      n_chk++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise got=%b required 1", irq); end
      axi_read(16'h1000, d, r, lat, sc);
      n_chk++;
      if (d !== 32'h4) begin n_fail++; $display("FAIL ctrl_after_exp got=%h required 4", d); end
      axi_write(16'h1004, 32'h1, 4'h1, r, c0);
      wait_until(c0 + 2);
      n_chk++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall got=%b required 0", irq); end
      axi_write(16'h1000, 32'h0, 4'hF, r, c0);
   endtask

   task automatic test_prescale;
      logic [31:0] d, e; logic [1:0] r; int lat, sc, c0, cx, k;
      axi_write(16'h1008, 32'd2, 4'hF, r, c0);
      axi_write(16'h1010, 32'd3, 4'hF, r, c0);
      axi_write(16'h1000, 32'h3, 4'hF, r, c0);
      for (int i = 0; i < 4; i++) begin
         wait_until(c0 + 2 + 4 * i);
         axi_read(16'h100C, d, r, lat, sc);
         k = (sc - c0) % 12;
         e = (k < 4) ? 32'd2 : (k < 8) ? 32'd1 : 32'd0;
         n_chk++;
         if (d !== e) begin
            n_fail++;
            $display("FAIL prescale_value phase=%0d got=%0d required %0d", k, d, e);
         end
      end
      wait_until(c0 + 26);
      axi_write(16'h1004, 32'h1, 4'h1, r, cx);
      axi_read(16'h1004, d, r, lat, sc);
      n_chk++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL prescale_w1c got=%h required 0", d); end
      wait_until(c0 + 34);
      axi_write(16'h1004, 32'h1, 4'h1, r, cx);
      n_chk++;
      if (cx !== c0 + 36) begin
         n_fail++;
         $display("FAIL w1c_alignment got=%0d required %0d", cx - c0, 36);
      end
      axi_read(16'h1004, d, r, lat, sc);
      n_chk++;
      if (d !== 32'd1) begin n_fail++; $display("FAIL hw_set_wins got=%h required 1", d); end
      axi_write(16'h1000, 32'h0, 4'hF, r, cx);
      axi_write(16'h1004, 32'h1, 4'h1, r, cx);
   endtask

   task automatic test_w_before_aw;
      logic bad; logic [31:0] d; logic [1:0] r; int lat, sc;
      bus.s_axi_wdata = 32'h0000_1234; bus.s_axi_wstrb = 4'hF;
      bus.s_axi_wvalid = 1'b1;
      @(posedge clk); #1;
      bus.s_axi_wvalid = 1'b0;
      n_chk++;
      if (bus.s_axi_wready !== 1'b0) begin n_fail++; $display("FAIL wready_drop got=%b required 0", bus.s_axi_wready); end
      bad = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         if (bus.s_axi_bvalid !== 1'b0 || bus.s_axi_wready !== 1'b0 || bus.s_axi_awready !== 1'b1) bad = 1'b1;
      end
      n_chk++;
      if (bad) begin n_fail++; $display("FAIL w_only_hold got=bad required bvalid0/wready0/awready1"); end
      bus.s_axi_awaddr = 16'h1010; bus.s_axi_awvalid = 1'b1;
      @(posedge clk); #1;
      bus.s_axi_awvalid = 1'b0;
      n_chk++;
      if (bus.s_axi_bvalid !== 1'b0 || bus.s_axi_awready !== 1'b0) begin
         n_fail++;
         $display("FAIL aw_accept got=%b%b required 00", bus.s_axi_bvalid, bus.s_axi_awready);
      end
      @(posedge clk); #1;
      n_chk++;
      if (bus.s_axi_bvalid !== 1'b1) begin n_fail++; $display("FAIL bvalid_rise got=%b required 1", bus.s_axi_bvalid); end
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (bus.s_axi_bvalid !== 1'b1 || bus.s_axi_awready !== 1'b0 || bus.s_axi_wready !== 1'b0) bad = 1'b1;
      end
      n_chk++;
      if (bad) begin n_fail++; $display("FAIL bvalid_hold got=bad required bvalid1/awready0/wready0"); end
      bus.s_axi_bready = 1'b1;
      @(posedge clk); #1;
      bus.s_axi_bready = 1'b0;
      n_chk++;
      if ({bus.s_axi_bvalid, bus.s_axi_awready, bus.s_axi_wready} !== 3'b011) begin
         n_fail++;
         $display("FAIL b_release got=%b%b%b required 011", bus.s_axi_bvalid, bus.s_axi_awready, bus.s_axi_wready);
      end
      axi_read(16'h1010, d, r, lat, sc);
      n_chk++;
      if (d !== 32'h0000_1234) begin n_fail++; $display("FAIL split_write_data got=%h required 00001234", d); end
   endtask

   task automatic test_strobes;
      logic [31:0] d; logic [1:0] r; int lat, sc, c0;
      axi_write(16'h1008, 32'd0, 4'hF, r, c0);
      axi_write(16'h1000, 32'h1, 4'hF, r, c0);
      axi_write(16'h1008, 32'hFFFF_FFFF, 4'b0010, r, c0);
      n_chk++;
      if (r !== 2'b00) begin n_fail++; $display("FAIL strobe_resp got=%b required 00", r); end
      axi_read(16'h1008, d, r, lat, sc);
      n_chk++;
      if (d !== 32'h0000_FF00) begin n_fail++; $display("FAIL load_strobe got=%h required 0000ff00", d); end
      axi_write(16'h1010, 32'hFFFF_FFFF, 4'hF, r, c0);
      axi_read(16'h1010, d, r, lat, sc);
      n_chk++;
      if (d !== 32'h0000_FFFF) begin n_fail++; $display("FAIL prescale_width got=%h required 0000ffff", d); end
      axi_write(16'h1000, 32'hFFFF_FFF8, 4'hF, r, c0);
      axi_read(16'h1000, d, r, lat, sc);
      n_chk++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL ctrl_unused_bits got=%h required 0", d); end
      axi_write(16'h100C, 32'h55, 4'hF, r, c0);
      n_chk++;
      if (r !== 2'b00) begin n_fail++; $display("FAIL value_wr_resp got=%b required 00", r); end
      axi_read(16'h100C, d, r, lat, sc);
      n_chk++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL value_ro got=%h required 0", d); end
      axi_write(16'h1004, 32'h1, 4'h1, r, c0);
   endtask

   task automatic test_slverr;
      logic [31:0] d; logic [1:0] r; int lat, sc, c0;
      axi_read(16'h1020, d, r, lat, sc);
      n_chk++;
      if (d !== 32'd0 || r !== 2'b10) begin n_fail++; $display("FAIL rd_slverr got=%h/%b required 0/10", d, r); end
      axi_write(16'h1020, 32'hDEAD_BEEF, 4'hF, r, c0);
      n_chk++;
      if (r !== 2'b10) begin n_fail++; $display("FAIL wr_slverr got=%b required 10", r); end
      axi_read(16'h000A, d, r, lat, sc);
      n_chk++;
      if (d !== 32'h0000_FF00 || r !== 2'b00) begin n_fail++; $display("FAIL addr_alias got=%h/%b required 0000ff00/00", d, r); end
   endtask

   task automatic test_back_to_back;
      int cnt;
      cnt = 0;
      bus.s_axi_araddr = 16'h1008; bus.s_axi_arvalid = 1'b1;
      bus.s_axi_rready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (bus.s_axi_arready === 1'b1) cnt++;
         @(posedge clk); #1;
      end
      bus.s_axi_arvalid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.s_axi_rready = 1'b0;
      n_chk++;
      if (cnt !== 5) begin n_fail++; $display("FAIL ar_rate got=%0d required 5", cnt); end
   endtask

   task automatic test_reset_mid;
      logic [31:0] d; logic [1:0] r; int lat, sc, c0, n;
      axi_write(16'h1008, 32'd0, 4'hF, r, c0);
      axi_write(16'h1010, 32'd0, 4'hF, r, c0);
      axi_write(16'h1000, 32'h7, 4'hF, r, c0);
      wait_until(c0 + 4);
      n_chk++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL autoreload_irq got=%b required 1", irq); end
      bus.s_axi_araddr = 16'h1000; bus.s_axi_arvalid = 1'b1; n = 0;
      while (bus.s_axi_arready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      bus.s_axi_arvalid = 1'b0;
      n_chk++;
      if (bus.s_axi_rvalid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_rvalid got=%b required 1", bus.s_axi_rvalid); end
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if ({bus.s_axi_rvalid, irq, bus.s_axi_arready} !== 3'b000) begin
         n_fail++;
         $display("FAIL async_reset got=%b%b%b required 000", bus.s_axi_rvalid, irq, bus.s_axi_arready);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      axi_read(16'h1000, d, r, lat, sc);
      n_chk++;
      if (d !== 32'd0 || r !== 2'b00 || lat !== 1) begin
         n_fail++;
         $display("FAIL post_reset_ctrl got=%h/%b/%0d required 0/00/1", d, r, lat);
      end
      axi_read(16'h1008, d, r, lat, sc);
      n_chk++;
      if (d !== RL) begin n_fail++; $display("FAIL post_reset_load got=%h required %h", d, RL); end
   endtask

   initial begin
      bus.s_axi_awaddr = '0; bus.s_axi_awvalid = 1'b0;
      bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wvalid = 1'b0;
      bus.s_axi_bready = 1'b0;
      bus.s_axi_araddr = '0; bus.s_axi_arvalid = 1'b0;
      bus.s_axi_rready = 1'b0;
      test_reset();
      test_oneshot();
      test_prescale();
      test_w_before_aw();
      test_strobes();
      test_slverr();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
